// File: rtl/layer_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// layer_seq_ctrl_if
// Bundles the upstream capture inputs, the downstream serial stream and the
// status/argmax outputs of layer_seq_ctrl.
//   i_valid   [NN]            per-neuron result valid pulses (upstream layer)
//   i_data    [NN*dataWidth]  packed neuron results, neuron n at [n*dataWidth +: dataWidth]
//   stall                     downstream hold
//   x_valid/x_out/x_last      serial element stream to the next layer
//   busy, err                 SEND-in-progress and sticky protocol error
//   max_idx, max_valid        argmax result (zero unless LAYER_SEQ_ARGMAX_EN)
// modport master : the environment (drives captures and stall)
// modport slave  : the sequencer
// -----------------------------------------------------------------------------
interface layer_seq_ctrl_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  localparam int IW = $clog2(NN);

  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    stall;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_out;
  logic                    x_last;
  logic                    busy;
  logic                    err;
  logic [IW-1:0]           max_idx;
  logic                    max_valid;

  modport master (
    output i_valid, i_data, stall,
    input  x_valid, x_out, x_last, busy, err, max_idx, max_valid
  );

  modport slave (
    input  i_valid, i_data, stall,
    output x_valid, x_out, x_last, busy, err, max_idx, max_valid
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// layer_seq_ctrl
// Inter-layer sequencer: captures the NN parallel results of one neuron layer
// into a buffer, then streams them one per cycle in neuron-index order as the
// serial input of the next layer. Honours a downstream stall and raises a
// sticky err on duplicate captures or captures arriving while streaming.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  layer_seq_ctrl_if.slave (capture inputs, serial stream, status)
// Build option:
//   LAYER_SEQ_ARGMAX_EN  track the signed maximum of the emitted elements and
//                        report its index (max_idx) with a max_valid pulse
//                        alongside x_last; otherwise both outputs are tied 0.
// -----------------------------------------------------------------------------
module layer_seq_ctrl #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  layer_seq_ctrl_if.slave   bus
);
  localparam int IW = $clog2(NN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [dataWidth-1:0] buf_mem [NN];
  logic [NN-1:0]        flag_q;
  logic [IW-1:0]        idx_q;
  logic                 x_valid_q, x_last_q, busy_q, err_q;
  logic [dataWidth-1:0] x_out_q;

  logic [NN-1:0] flag_nxt;
  logic          capture, start, emit, last_idx, frame_done, proto_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flag_nxt   = flag_q | bus.i_valid;
    capture    = 1'b0;
    start      = 1'b0;
    emit       = 1'b0;
    frame_done = 1'b0;
    proto_err  = 1'b0;
    last_idx   = (idx_q == IW'(NN - 1));
    case (state_q)
      IDLE: begin
        capture   = 1'b1;
        proto_err = |(bus.i_valid & flag_q);
        if (&flag_nxt) begin
          start   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        proto_err = |bus.i_valid;
        if (!bus.stall) begin
          emit = 1'b1;
          if (last_idx) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned n = 0; n < NN; n++) begin
        if (bus.i_valid[n]) buf_mem[n] <= bus.i_data[n*dataWidth +: dataWidth];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q    <= '0;
      idx_q     <= '0;
      x_valid_q <= 1'b0;
      x_out_q   <= '0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      if (proto_err) err_q <= 1'b1;
      if (capture)   flag_q <= flag_nxt;
      if (start) begin
        idx_q  <= '0;
        busy_q <= 1'b1;
      end
      if (emit) begin
        x_valid_q <= 1'b1;
        x_out_q   <= buf_mem[idx_q];
        x_last_q  <= last_idx;
        idx_q     <= idx_q + 1'b1;
      end
      if (frame_done) begin
        flag_q <= '0;
        idx_q  <= '0;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.x_valid = x_valid_q;
  assign bus.x_out   = x_out_q;
  assign bus.x_last  = x_last_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

`ifdef LAYER_SEQ_ARGMAX_EN
  logic signed [dataWidth-1:0] run_max_q;
  logic [IW-1:0]               max_idx_q;
  logic                        max_valid_q;
  logic signed [dataWidth-1:0] cur;
  logic                        upd;

  // Index 0 seeds the running maximum; strict compare keeps the lower index on ties.
  always_comb begin
    cur = $signed(buf_mem[idx_q]);
    upd = (idx_q == '0) || (cur > run_max_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_valid_q <= 1'b0;
      if (emit) begin
        if (upd) begin
          run_max_q <= cur;
          max_idx_q <= idx_q;
        end
        max_valid_q <= last_idx;
      end
    end
  end

  assign bus.max_idx   = max_idx_q;
  assign bus.max_valid = max_valid_q;
`else
  assign bus.max_idx   = '0;
  assign bus.max_valid = 1'b0;
`endif
endmodule
